// File: rtl/gem_tx_seq_pkg.sv
// Shared types and constants for the GEM transmit-side sequencer.
package gem_tx_seq_pkg;

    localparam int FRAMES_W    = 16;
    localparam int UNDERFLOW_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RDY      = 3'd1,
        ST_XFER     = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_WAIT_END = 3'd4
    } tx_state_t;

    // Only RDY and XFER may legally answer a MAC read request.
    function automatic logic rd_window(input tx_state_t s);
        return (s == ST_RDY) || (s == ST_XFER);
    endfunction

endpackage

// File: rtl/gem_toggle_detect.sv
// Turns a level toggle from another domain-side handshake into a one-cycle change pulse.
module gem_toggle_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic change
);

    logic level_q;
    logic armed;

    // The copy is loaded on the first clock after reset release, so the level held across reset never reads as a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            level_q <= level;
            armed   <= 1'b1;
        end
    end

    assign change = armed & (level ^ level_q);

endmodule

// File: rtl/gem_tx_sequencer.sv
// Feeds buffered frame bytes to the GEM TX read interface and collects per-frame status.
module gem_tx_sequencer
    import gem_tx_seq_pkg::*;
(
    input  logic                   tx_clock,
    input  logic                   tx_resetn,
    input  logic [7:0]             s_tdata,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    input  logic                   s_terr,
    output logic                   s_tready,
    input  logic                   s_frame_pending,
    output logic                   tx_r_data_rdy,
    output logic                   tx_r_valid,
    output logic [7:0]             tx_r_data,
    output logic                   tx_r_sop,
    output logic                   tx_r_eop,
    output logic                   tx_r_err,
    output logic                   tx_r_underflow,
    output logic                   tx_r_flushed,
    output logic                   tx_r_control,
    input  logic                   tx_r_rd,
    input  logic [3:0]             tx_r_status,
    input  logic                   tx_r_fixed_lat,
    input  logic                   dma_tx_end_tog,
    output logic                   dma_tx_status_tog,
    output logic                   frame_done,
    output logic [3:0]             frame_status,
    output logic [FRAMES_W-1:0]    frames_sent,
    output logic [UNDERFLOW_W-1:0] underflows,
    output logic                   proto_err
);

    tx_state_t              state, state_nxt;
    logic                   in_window, take, starve, end_chg, done_now;
    logic [FRAMES_W-1:0]    frames_cnt;
    logic [UNDERFLOW_W-1:0] underflow_cnt;
    logic                   unused_fixed_lat;

    // Read latency is always one cycle, so the MAC's latency hint has no effect.
    assign unused_fixed_lat = tx_r_fixed_lat;

    gem_toggle_detect u_end_detect (
        .clk    (tx_clock),
        .rst_n  (tx_resetn),
        .level  (dma_tx_end_tog),
        .change (end_chg)
    );

    assign in_window     = rd_window(state);
    assign take          = in_window & tx_r_rd & s_tvalid;
    assign starve        = in_window & tx_r_rd & ~s_tvalid;
    assign done_now      = (state == ST_WAIT_END) & end_chg;
    assign s_tready      = take | (state == ST_DRAIN);
    assign tx_r_data_rdy = in_window;
    assign tx_r_flushed  = 1'b0;
    assign tx_r_control  = 1'b0;
    assign frames_sent   = frames_cnt;
    assign underflows    = underflow_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (s_frame_pending) state_nxt = ST_RDY;
            ST_RDY, ST_XFER: begin
                if (take)        state_nxt = s_tlast ? ST_WAIT_END : ST_XFER;
                else if (starve) state_nxt = ST_DRAIN;
            end
            ST_DRAIN:    if (s_tvalid && s_tlast) state_nxt = ST_WAIT_END;
            ST_WAIT_END: if (end_chg) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge tx_clock or negedge tx_resetn) begin
        if (!tx_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An underflow beat is still presented as valid so the MAC sees the gap, carrying zero data.
    always_ff @(posedge tx_clock or negedge tx_resetn) begin
        if (!tx_resetn) begin
            tx_r_valid     <= 1'b0;
            tx_r_data      <= 8'h00;
            tx_r_sop       <= 1'b0;
            tx_r_eop       <= 1'b0;
            tx_r_err       <= 1'b0;
            tx_r_underflow <= 1'b0;
            proto_err      <= 1'b0;
        end else begin
            tx_r_valid     <= take | starve;
            tx_r_data      <= take ? s_tdata : 8'h00;
            tx_r_sop       <= take & (state == ST_RDY);
            tx_r_eop       <= take & s_tlast;
            tx_r_err       <= take & s_tlast & s_terr;
            tx_r_underflow <= starve;
            proto_err      <= tx_r_rd & ~in_window;
        end
    end

    always_ff @(posedge tx_clock or negedge tx_resetn) begin
        if (!tx_resetn) begin
            frame_done        <= 1'b0;
            frame_status      <= 4'h0;
            dma_tx_status_tog <= 1'b0;
            frames_cnt        <= '0;
            underflow_cnt     <= '0;
        end else begin
            frame_done <= done_now;
            if (done_now) begin
                frame_status      <= tx_r_status;
                dma_tx_status_tog <= ~dma_tx_status_tog;
                frames_cnt        <= frames_cnt + FRAMES_W'(1);
            end
            if (starve && (underflow_cnt != {UNDERFLOW_W{1'b1}})) begin
                underflow_cnt <= underflow_cnt + UNDERFLOW_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gem_tx_sequencer.sv
// Directed self-checking bench for gem_tx_sequencer.
module tb_gem_tx_sequencer;

    logic        tx_clock;
    logic        tx_resetn;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, s_terr, s_tready, s_frame_pending;
    logic        tx_r_data_rdy, tx_r_valid, tx_r_sop, tx_r_eop, tx_r_err;
    logic [7:0]  tx_r_data;
    logic        tx_r_underflow, tx_r_flushed, tx_r_control;
    logic        tx_r_rd, tx_r_fixed_lat, dma_tx_end_tog, dma_tx_status_tog;
    logic [3:0]  tx_r_status, frame_status;
    logic        frame_done, proto_err;
    logic [15:0] frames_sent;
    logic [7:0]  underflows;

    int checks = 0;
    int errors = 0;

    gem_tx_sequencer dut (
        .tx_clock          (tx_clock),
        .tx_resetn         (tx_resetn),
        .s_tdata           (s_tdata),
        .s_tvalid          (s_tvalid),
        .s_tlast           (s_tlast),
        .s_terr            (s_terr),
        .s_tready          (s_tready),
        .s_frame_pending   (s_frame_pending),
        .tx_r_data_rdy     (tx_r_data_rdy),
        .tx_r_valid        (tx_r_valid),
        .tx_r_data         (tx_r_data),
        .tx_r_sop          (tx_r_sop),
        .tx_r_eop          (tx_r_eop),
        .tx_r_err          (tx_r_err),
        .tx_r_underflow    (tx_r_underflow),
        .tx_r_flushed      (tx_r_flushed),
        .tx_r_control      (tx_r_control),
        .tx_r_rd           (tx_r_rd),
        .tx_r_status       (tx_r_status),
        .tx_r_fixed_lat    (tx_r_fixed_lat),
        .dma_tx_end_tog    (dma_tx_end_tog),
        .dma_tx_status_tog (dma_tx_status_tog),
        .frame_done        (frame_done),
        .frame_status      (frame_status),
        .frames_sent       (frames_sent),
        .underflows        (underflows),
        .proto_err         (proto_err)
    );

    initial tx_clock = 1'b0;
    always #5 tx_clock = ~tx_clock;

    task automatic clear_inputs();
        s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; s_terr = 1'b0;
        tx_r_rd = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge tx_clock); #1;
        checks++;
        if ({s_tready, tx_r_data_rdy, tx_r_valid, tx_r_data, tx_r_sop, tx_r_eop, tx_r_err,
             tx_r_underflow, tx_r_flushed, tx_r_control, dma_tx_status_tog, frame_done,
             frame_status, frames_sent, underflows, proto_err} !== 48'h0) begin
            errors++; $display("[TB] FAIL reset_outputs: outputs not all zero during reset");
        end
        @(negedge tx_clock);
        tx_resetn = 1'b1;
        @(negedge tx_clock);
        @(negedge tx_clock);
        checks++;
        if (tx_r_data_rdy !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_release: data_rdy=%b frame_done=%b expected 0/0", tx_r_data_rdy, frame_done);
        end
    endtask

    task automatic test_normal_frame();
        logic [7:0] bytes [4];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        s_frame_pending = 1'b1;
        @(negedge tx_clock);
        checks++;
        if (tx_r_data_rdy !== 1'b1) begin
            errors++; $display("[TB] FAIL rdy_entry: data_rdy=%b expected 1", tx_r_data_rdy);
        end
        for (int k = 0; k < 4; k++) begin
            s_tdata = bytes[k]; s_tvalid = 1'b1; s_tlast = (k == 3); tx_r_rd = 1'b1;
            #1;
            checks++;
            if (s_tready !== 1'b1) begin
                errors++; $display("[TB] FAIL normal_tready[%0d]: got %b expected 1", k, s_tready);
            end
            @(negedge tx_clock);
            checks++;
            if ({tx_r_valid, tx_r_sop, tx_r_eop, tx_r_err, tx_r_data} !== {1'b1, k == 0, k == 3, 1'b0, bytes[k]}) begin
                errors++;
                $display("[TB] FAIL normal_beat[%0d]: valid/sop/eop/err/data got %b%b%b%b/%h expected 1%b%b0/%h",
                         k, tx_r_valid, tx_r_sop, tx_r_eop, tx_r_err, tx_r_data, k == 0, k == 3, bytes[k]);
            end
        end
        clear_inputs();
        #1;
        checks++;
        if (tx_r_data_rdy !== 1'b0 || s_tready !== 1'b0) begin
            errors++; $display("[TB] FAIL eop_rdy_drop: data_rdy=%b tready=%b expected 0/0", tx_r_data_rdy, s_tready);
        end
        @(negedge tx_clock);
        checks++;
        if (tx_r_valid !== 1'b0 || tx_r_data_rdy !== 1'b0 || tx_r_flushed !== 1'b0 || tx_r_control !== 1'b0) begin
            errors++; $display("[TB] FAIL wait_end_hold: valid=%b data_rdy=%b flushed=%b control=%b expected 0000",
                               tx_r_valid, tx_r_data_rdy, tx_r_flushed, tx_r_control);
        end
        s_frame_pending = 1'b0;
    endtask

    task automatic test_completion();
        tx_r_status = 4'h5;
        dma_tx_end_tog = ~dma_tx_end_tog;
        @(negedge tx_clock);
        checks++;
        if ({frame_done, frame_status, dma_tx_status_tog, frames_sent} !== {1'b1, 4'h5, 1'b1, 16'd1}) begin
            errors++; $display("[TB] FAIL completion: done=%b status=%h tog=%b frames=%0d expected 1/5/1/1",
                               frame_done, frame_status, dma_tx_status_tog, frames_sent);
        end
        @(negedge tx_clock);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("[TB] FAIL done_pulse_width: got %b expected 0", frame_done);
        end
        dma_tx_end_tog = ~dma_tx_end_tog;
        tx_r_status = 4'hC;
        @(negedge tx_clock);
        checks++;
        if (frame_done !== 1'b0 || frames_sent !== 16'd1 || frame_status !== 4'h5) begin
            errors++; $display("[TB] FAIL idle_toggle_ignored: done=%b frames=%0d status=%h expected 0/1/5",
                               frame_done, frames_sent, frame_status);
        end
    endtask

    task automatic test_proto_err();
        tx_r_rd = 1'b1;
        @(negedge tx_clock);
        tx_r_rd = 1'b0;
        checks++;
        if (proto_err !== 1'b1 || tx_r_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL proto_idle: proto_err=%b valid=%b expected 1/0", proto_err, tx_r_valid);
        end
        @(negedge tx_clock);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++; $display("[TB] FAIL proto_pulse_width: got %b expected 0", proto_err);
        end
    endtask

    task automatic test_underflow();
        logic [7:0] rest [3];
        rest[0] = 8'hB2; rest[1] = 8'hC3; rest[2] = 8'hD4;
        s_frame_pending = 1'b1;
        @(negedge tx_clock);
        s_frame_pending = 1'b0;
        s_tdata = 8'hA1; s_tvalid = 1'b1; tx_r_rd = 1'b1;
        @(negedge tx_clock);
        checks++;
        if ({tx_r_valid, tx_r_sop, tx_r_data} !== {2'b11, 8'hA1}) begin
            errors++; $display("[TB] FAIL uf_first_byte: valid=%b sop=%b data=%h expected 1/1/a1", tx_r_valid, tx_r_sop, tx_r_data);
        end
        s_tvalid = 1'b0;
        #1;
        checks++;
        if (s_tready !== 1'b0) begin
            errors++; $display("[TB] FAIL uf_no_tready: got %b expected 0", s_tready);
        end
        @(negedge tx_clock);
        checks++;
        if ({tx_r_underflow, tx_r_valid, tx_r_data, underflows} !== {2'b11, 8'h00, 8'd1}) begin
            errors++; $display("[TB] FAIL uf_beat: underflow=%b valid=%b data=%h count=%0d expected 1/1/00/1",
                               tx_r_underflow, tx_r_valid, tx_r_data, underflows);
        end
        tx_r_rd = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_tdata = rest[k]; s_tvalid = 1'b1; s_tlast = (k == 2);
            #1;
            checks++;
            if (s_tready !== 1'b1) begin
                errors++; $display("[TB] FAIL drain_tready[%0d]: got %b expected 1", k, s_tready);
            end
            @(negedge tx_clock);
            checks++;
            if (tx_r_valid !== 1'b0 || tx_r_underflow !== 1'b0) begin
                errors++; $display("[TB] FAIL drain_silent[%0d]: valid=%b underflow=%b expected 0/0", k, tx_r_valid, tx_r_underflow);
            end
        end
        clear_inputs();
        #1;
        checks++;
        if (s_tready !== 1'b0 || tx_r_data_rdy !== 1'b0) begin
            errors++; $display("[TB] FAIL drain_exit: tready=%b data_rdy=%b expected 0/0", s_tready, tx_r_data_rdy);
        end
        tx_r_status = 4'hA;
        dma_tx_end_tog = ~dma_tx_end_tog;
        @(negedge tx_clock);
        checks++;
        if ({frame_done, frame_status, frames_sent} !== {1'b1, 4'hA, 16'd2}) begin
            errors++; $display("[TB] FAIL uf_completion: done=%b status=%h frames=%0d expected 1/a/2", frame_done, frame_status, frames_sent);
        end
    endtask

    task automatic run_underflow_frame();
        s_frame_pending = 1'b1;
        @(negedge tx_clock);
        s_frame_pending = 1'b0;
        tx_r_rd = 1'b1;
        @(negedge tx_clock);
        tx_r_rd = 1'b0; s_tvalid = 1'b1; s_tlast = 1'b1;
        @(negedge tx_clock);
        clear_inputs();
        dma_tx_end_tog = ~dma_tx_end_tog;
        @(negedge tx_clock);
    endtask

    task automatic test_underflow_saturate();
        for (int i = 0; i < 254; i++) run_underflow_frame();
        checks++;
        if (underflows !== 8'd255) begin
            errors++; $display("[TB] FAIL uf_count_255: got %0d expected 255", underflows);
        end
        run_underflow_frame();
        checks++;
        if (underflows !== 8'd255 || frames_sent !== 16'd257) begin
            errors++; $display("[TB] FAIL uf_saturate: underflows=%0d frames=%0d expected 255/257", underflows, frames_sent);
        end
    endtask

    task automatic test_frame_wrap();
        force dut.frames_cnt = 16'hFFFF;
        @(negedge tx_clock);
        release dut.frames_cnt;
        s_frame_pending = 1'b1;
        @(negedge tx_clock);
        s_frame_pending = 1'b0;
        s_tdata = 8'h5A; s_tvalid = 1'b1; s_tlast = 1'b1; s_terr = 1'b1; tx_r_rd = 1'b1;
        @(negedge tx_clock);
        checks++;
        if ({tx_r_valid, tx_r_sop, tx_r_eop, tx_r_err, tx_r_data} !== {4'b1111, 8'h5A}) begin
            errors++; $display("[TB] FAIL single_err_beat: valid/sop/eop/err/data got %b%b%b%b/%h expected 1111/5a",
                               tx_r_valid, tx_r_sop, tx_r_eop, tx_r_err, tx_r_data);
        end
        clear_inputs();
        tx_r_status = 4'h3;
        dma_tx_end_tog = ~dma_tx_end_tog;
        @(negedge tx_clock);
        checks++;
        if ({frame_done, frame_status, frames_sent} !== {1'b1, 4'h3, 16'd0}) begin
            errors++; $display("[TB] FAIL frames_wrap: done=%b status=%h frames=%0d expected 1/3/0", frame_done, frame_status, frames_sent);
        end
    endtask

    task automatic test_reset_mid_frame();
        s_frame_pending = 1'b1;
        @(negedge tx_clock);
        s_frame_pending = 1'b0;
        s_tdata = 8'h77; s_tvalid = 1'b1; tx_r_rd = 1'b1;
        @(negedge tx_clock);
        tx_resetn = 1'b0;
        #1;
        checks++;
        if ({s_tready, tx_r_data_rdy, tx_r_valid, tx_r_data, tx_r_sop, tx_r_eop, tx_r_err,
             tx_r_underflow, tx_r_flushed, tx_r_control, dma_tx_status_tog, frame_done,
             frame_status, frames_sent, underflows, proto_err} !== 48'h0) begin
            errors++; $display("[TB] FAIL reset_mid_xfer: outputs not all zero (valid=%b data=%h uf=%0d)", tx_r_valid, tx_r_data, underflows);
        end
        clear_inputs();
        dma_tx_end_tog = ~dma_tx_end_tog;
        @(negedge tx_clock);
        tx_resetn = 1'b1;
        @(negedge tx_clock);
        checks++;
        if (frame_done !== 1'b0 || tx_r_data_rdy !== 1'b0) begin
            errors++; $display("[TB] FAIL post_reset_1: done=%b data_rdy=%b expected 0/0", frame_done, tx_r_data_rdy);
        end
        @(negedge tx_clock);
        checks++;
        if (frame_done !== 1'b0 || frames_sent !== 16'd0) begin
            errors++; $display("[TB] FAIL post_reset_2: done=%b frames=%0d expected 0/0", frame_done, frames_sent);
        end
        s_frame_pending = 1'b1;
        @(negedge tx_clock);
        s_frame_pending = 1'b0;
        checks++;
        if (tx_r_data_rdy !== 1'b1) begin
            errors++; $display("[TB] FAIL restart_from_idle: data_rdy=%b expected 1", tx_r_data_rdy);
        end
    endtask

    initial begin
        tx_resetn = 1'b0;
        clear_inputs();
        s_frame_pending = 1'b0;
        tx_r_status = 4'h0;
        tx_r_fixed_lat = 1'b1;
        dma_tx_end_tog = 1'b0;
        test_reset();
        test_normal_frame();
        test_completion();
        test_proto_err();
        test_underflow();
        test_underflow_saturate();
        test_frame_wrap();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule

// File: doc/gem_tx_sequencer.md
GEM_TX_SEQUENCER -- requirements
Module: gem_tx_sequencer

Interface
REQ-001 SHALL have one clock, tx_clock (input, 1): all logic on its rising edge.
REQ-002 SHALL have reset tx_resetn (input, 1): asynchronous, active-low.
REQ-003 SHALL have s_tdata (input, 8): upstream frame byte.
REQ-004 SHALL have s_tvalid (input, 1): upstream byte valid.
REQ-005 SHALL have s_tlast (input, 1): last byte of frame.
REQ-006 SHALL have s_terr (input, 1): frame bad, sampled with s_tlast.
REQ-007 SHALL have s_tready (output, 1): byte consumed this cycle.
REQ-008 SHALL have s_frame_pending (input, 1): at least one complete frame buffered upstream.
REQ-009 SHALL drive the GEM TX side: tx_r_data_rdy, tx_r_valid, tx_r_data[7:0], tx_r_sop, tx_r_eop, tx_r_err, tx_r_underflow, tx_r_flushed, tx_r_control (outputs).
REQ-010 SHALL take tx_r_rd, tx_r_status[3:0], tx_r_fixed_lat and dma_tx_end_tog as inputs, and drive dma_tx_status_tog as an output.
REQ-011 SHALL have frame_done (output, 1): one-cycle pulse when a frame's status is captured.
REQ-012 SHALL have frame_status (output, 4): last captured tx_r_status.
REQ-013 SHALL have frames_sent (output, 16): wrapping count of completed frames.
REQ-014 SHALL have underflows (output, 8): saturating underflow count.
REQ-015 SHALL have proto_err (output, 1): one-cycle pulse on an unexpected tx_r_rd.

Function
REQ-016 SHALL implement the states IDLE, RDY, XFER, DRAIN, WAIT_END.
REQ-017 IDLE: on s_frame_pending=1, SHALL go to RDY; tx_r_data_rdy SHALL be 1 in RDY and XFER only.
REQ-018 RDY/XFER, tx_r_rd=1, s_tvalid=1: SHALL assert s_tready that cycle and present the byte the next cycle on tx_r_valid=1/tx_r_data (fixed latency 1, irrespective of tx_r_fixed_lat).
REQ-019 tx_r_sop SHALL be 1 with the first byte of a frame; tx_r_eop SHALL be 1 with the s_tlast byte; tx_r_err SHALL be equal to s_terr on that eop beat and 0 otherwise.
REQ-020 The first tx_r_rd in RDY SHALL move the block to XFER; the eop beat SHALL move it to WAIT_END, with tx_r_data_rdy deasserted from the cycle after the eop read.
REQ-021 Underflow: tx_r_rd=1 and s_tvalid=0 in RDY/XFER SHALL assert tx_r_underflow=1 and tx_r_valid=1 (data 0) the next cycle, increment underflows (saturating at 255), and move the block to DRAIN.
REQ-022 DRAIN SHALL hold s_tready=1, discard bytes through s_tlast, then move to WAIT_END; in DRAIN, tx_r_valid SHALL be 0.
REQ-023 WAIT_END: a change of dma_tx_end_tog from its registered value SHALL capture tx_r_status into frame_status, pulse frame_done, toggle dma_tx_status_tog, increment frames_sent (wrapping 0xFFFF->0) and return to IDLE, all in the same cycle.
REQ-024 A toggle of dma_tx_end_tog in any other state SHALL update the registered copy only and SHALL be otherwise ignored.
REQ-025 tx_r_rd in IDLE, DRAIN or WAIT_END SHALL produce no tx_r_valid and SHALL pulse proto_err.
REQ-026 tx_r_flushed and tx_r_control SHALL be constant 0.
REQ-027 An eop beat coinciding with s_frame_pending=1 SHALL NOT skip WAIT_END; a new frame starts only from IDLE.

Reset
REQ-028 While tx_resetn=0, all outputs SHALL be 0, the state SHALL be IDLE, the counters SHALL be 0, and the end-toggle copy SHALL load dma_tx_end_tog on reset release.
REQ-029 Reset mid-frame SHALL abandon the frame without an upstream drain; upstream is reset jointly.

Structure
REQ-030 Package gem_tx_seq_pkg SHALL hold the state enum and the counter width constants (FRAMES_W=16, UNDERFLOW_W=8).
REQ-031 Toggle change detection SHALL be in sub-module gem_toggle_detect (input level, output one-cycle change pulse, registered copy).

Verification
REQ-032 Normal frame: pending=1, 4 bytes 0x11..0x44 with tlast on 0x44, tx_r_rd held for 4 cycles -> valid for 4 cycles one cycle later, sop on 0x11, eop on 0x44, err=0, data_rdy low afterward.
REQ-033 Completion: toggle dma_tx_end_tog with tx_r_status=4'h5 in WAIT_END -> frame_done pulse, frame_status=5, dma_tx_status_tog flips, frames_sent=1, state IDLE.
REQ-034 Underflow: tx_r_rd at byte 2 with s_tvalid=0 -> tx_r_underflow=1 next cycle, underflows=1, remaining 3 bytes consumed silently, then WAIT_END.
REQ-035 Protocol error: tx_r_rd in IDLE -> proto_err pulse, tx_r_valid stays 0.
REQ-036 Wrap: preload 65535 frames, complete one more -> frames_sent=0; with 256 underflows -> underflows=255.
REQ-037 Async reset asserted mid-XFER -> all outputs 0 immediately, IDLE after release, no spurious frame_done.
